// File: rtl/kv_lru_engine.sv
// True-LRU replacement engine: per-set age permutation in flops, one request per cycle,
// with init sequencing, invalid-way preference on fill and a registered victim response.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   ST_INIT | rebuilding set r_cnt to the identity permutation, o_ready low
//   ST_RUN  | accepting touch / fill / invalidate / flush requests
module kv_lru_engine #(
   parameter int WAY_NUM     = 4,
   parameter int LINE_NUM    = 64,
   parameter int INDEX_WIDTH = $clog2(LINE_NUM / WAY_NUM),
   parameter int AGE_W       = $clog2(WAY_NUM)
) (
   input  logic                   i_clk,
   input  logic                   i_rstn,
   output logic                   o_ready,
   input  logic                   i_req_valid,
   input  logic [1:0]             i_req_op,
   input  logic [INDEX_WIDTH-1:0] i_req_index,
   input  logic [WAY_NUM-1:0]     i_req_way,
   input  logic [WAY_NUM-1:0]     i_valid_way,
   output logic                   o_rsp_valid,
   output logic [WAY_NUM-1:0]     o_victim_way,
   output logic [AGE_W-1:0]       o_victim_idx
);

   localparam int SET_NUM = LINE_NUM / WAY_NUM;

   localparam logic [1:0] OP_TOUCH = 2'b00;
   localparam logic [1:0] OP_FILL  = 2'b01;
   localparam logic [1:0] OP_INVAL = 2'b10;
   localparam logic [1:0] OP_FLUSH = 2'b11;

   localparam logic [AGE_W-1:0]       AGE_LRU  = AGE_W'(WAY_NUM - 1);
   localparam logic [INDEX_WIDTH-1:0] CNT_LAST = INDEX_WIDTH'(SET_NUM - 1);

   typedef logic [WAY_NUM-1:0][AGE_W-1:0] row_t;
   typedef enum logic {ST_INIT, ST_RUN} state_t;

   function automatic row_t identity_row();
      row_t row;
      for (int w = 0; w < WAY_NUM; w++) row[w] = AGE_W'(w);
      return row;
   endfunction

   function automatic logic is_perm(input row_t row);
      logic [WAY_NUM-1:0] seen;
      seen = '0;
      for (int w = 0; w < WAY_NUM; w++) seen[row[w]] = 1'b1;
      return &seen;
   endfunction

   state_t                   r_state;
   logic [INDEX_WIDTH-1:0]   r_cnt;
   logic                     r_ready;
   logic                     r_rsp_valid;
   logic [WAY_NUM-1:0]       r_victim_way;
   logic [AGE_W-1:0]         r_victim_idx;
   row_t                     r_age [SET_NUM];

   row_t                     w_row;
   row_t                     w_new_row;
   logic                     w_accept;
   logic                     w_sel_hit;
   logic                     w_inv_any;
   logic                     w_do_touch;
   logic                     w_do_inval;
   logic [AGE_W-1:0]         w_sel_idx;
   logic [AGE_W-1:0]         w_inv_idx;
   logic [AGE_W-1:0]         w_lru_idx;
   logic [AGE_W-1:0]         w_vic_idx;
   logic [AGE_W-1:0]         w_tgt_idx;
   logic [AGE_W-1:0]         w_tgt_age;

   assign w_accept = i_req_valid && r_ready;

   always_comb begin
      w_row     = r_age[i_req_index];
      w_sel_hit = 1'b0;
      w_sel_idx = '0;
      w_inv_any = 1'b0;
      w_inv_idx = '0;
      w_lru_idx = '0;
      // descending scans leave the lowest matching way selected
      for (int w = WAY_NUM - 1; w >= 0; w--) begin
         if (i_req_way[w]) begin
            w_sel_hit = 1'b1;
            w_sel_idx = AGE_W'(w);
         end
         if (!i_valid_way[w]) begin
            w_inv_any = 1'b1;
            w_inv_idx = AGE_W'(w);
         end
         if (w_row[w] == AGE_LRU) w_lru_idx = AGE_W'(w);
      end
      w_vic_idx  = w_inv_any ? w_inv_idx : w_lru_idx;
      w_tgt_idx  = (i_req_op == OP_FILL) ? w_vic_idx : w_sel_idx;
      w_tgt_age  = w_row[w_tgt_idx];
      w_do_touch = (i_req_op == OP_FILL) || ((i_req_op == OP_TOUCH) && w_sel_hit);
      w_do_inval = (i_req_op == OP_INVAL) && w_sel_hit;
      w_new_row  = w_row;
      for (int w = 0; w < WAY_NUM; w++) begin
         if (w_do_touch) begin
            if (AGE_W'(w) == w_tgt_idx)    w_new_row[w] = '0;
            else if (w_row[w] < w_tgt_age) w_new_row[w] = w_row[w] + AGE_W'(1);
         end else if (w_do_inval) begin
            if (AGE_W'(w) == w_tgt_idx)    w_new_row[w] = AGE_LRU;
            else if (w_row[w] > w_tgt_age) w_new_row[w] = w_row[w] - AGE_W'(1);
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         r_state      <= ST_INIT;
         r_cnt        <= '0;
         r_ready      <= 1'b0;
         r_rsp_valid  <= 1'b0;
         r_victim_way <= '0;
         r_victim_idx <= '0;
      end else begin
         r_rsp_valid <= 1'b0;
         case (r_state)
            ST_INIT: begin
               r_age[r_cnt] <= identity_row();
               if (r_cnt == CNT_LAST) begin
                  r_state <= ST_RUN;
                  r_ready <= 1'b1;
                  r_cnt   <= '0;
               end else begin
                  r_cnt <= r_cnt + INDEX_WIDTH'(1);
               end
            end
            ST_RUN: begin
               if (w_accept) begin
                  r_rsp_valid <= 1'b1;
                  if (i_req_op == OP_FILL) begin
                     r_victim_way <= WAY_NUM'(1) << w_vic_idx;
                     r_victim_idx <= w_vic_idx;
                  end else begin
                     r_victim_way <= '0;
                     r_victim_idx <= '0;
                  end
                  if (i_req_op == OP_FLUSH) begin
                     r_state <= ST_INIT;
                     r_ready <= 1'b0;
                     r_cnt   <= '0;
                  end else begin
                     r_age[i_req_index] <= w_new_row;
                  end
               end
            end
            default: begin
               r_state <= ST_INIT;
               r_ready <= 1'b0;
               r_cnt   <= '0;
            end
         endcase
      end
   end

   assign o_ready      = r_ready;
   assign o_rsp_valid  = r_rsp_valid;
   assign o_victim_way = r_victim_way;
   assign o_victim_idx = r_victim_idx;

   // every set must stay a permutation of 0..WAY_NUM-1 once init has finished
   for (genvar s = 0; s < SET_NUM; s++) begin : g_perm_chk
      a_perm: assert property (@(posedge i_clk) disable iff (!i_rstn) r_ready |-> is_perm(r_age[s]));
   end

endmodule

// File: doc/kv_lru_engine.md
Name: kv_lru_engine

Overview:
- Parametrised true-LRU replacement engine for set-associative caches (I$/D$).
- Keeps a per-set age permutation in flops and accepts one request per cycle: touch on hit, fill/victim select on miss, invalidate, or flush.
- Adds init sequencing, invalid-way preference and a registered victim response.
- Sits beside the tag array and feeds the refill/kill logic.

Parameters:
- WAY_NUM, 4: associativity; power of 2, at least 2.
- LINE_NUM, 64: total lines; SET_NUM = LINE_NUM/WAY_NUM (derived); LINE_NUM must be a multiple of WAY_NUM.
- INDEX_WIDTH, $clog2(LINE_NUM/WAY_NUM): derived set-index width.
- AGE_W, $clog2(WAY_NUM): derived age width.

Ports:
- i_clk  in  1  clock
- i_rstn  in  1  synchronous active-low reset
- o_ready  out  1  init complete; requests accepted only when high
- i_req_valid  in  1  request strobe
- i_req_op  in  2  00 touch, 01 fill, 10 invalidate, 11 flush
- i_req_index  in  INDEX_WIDTH  set index
- i_req_way  in  WAY_NUM  one-hot way (touch/invalidate)
- i_valid_way  in  WAY_NUM  way valid bits of the indexed set (fill)
- o_rsp_valid  out  1  one-cycle response pulse
- o_victim_way  out  WAY_NUM  one-hot victim (fill), else 0
- o_victim_idx  out  AGE_W  binary victim index (fill), else 0

Behaviour:
- Synchronous active-low reset: all flop updates happen on the i_clk edge.
- Storage: age[set][way], AGE_W bits each. Each set always holds a permutation of 0..WAY_NUM-1; 0 = MRU, WAY_NUM-1 = LRU.
- Reset values: o_ready=0, o_rsp_valid=0, o_victim_way=0, o_victim_idx=0. FSM enters INIT with set counter 0.
- INIT state:
  - Each cycle writes age[cnt][w]=w for all w, then increments cnt.
  - After SET_NUM cycles (cnt==SET_NUM-1 written), goes to RUN; o_ready=1 from the next cycle.
  - Requests arriving while o_ready=0 are ignored, with no response.
- RUN state: request accepted when i_req_valid && o_ready. Ages are read from flops in the accept cycle, the update is written at that edge, and o_rsp_valid=1 the following cycle only.
- Touch (00), target way h with age a:
  - Every way with age<a increments; h becomes 0; all others unchanged.
  - If i_req_way==0: no state change, response still issued.
  - If i_req_way has several bits set: the lowest set bit is used.
- Fill (01):
  - If any i_valid_way bit is 0, victim = lowest-index invalid way; otherwise victim = the way with age WAY_NUM-1.
  - The victim is then touched (becomes MRU) in the same update.
  - o_victim_way and o_victim_idx report the victim.
- Invalidate (10), target way w with age a:
  - Ways with age>a decrement; w becomes WAY_NUM-1.
  - Zero / multi-hot i_req_way handled as for touch.
- Flush (11):
  - Response pulse next cycle; o_ready=0 from the next cycle.
  - FSM returns to INIT with cnt=0 and rebuilds all sets over SET_NUM cycles.
- Response outputs: o_victim_way and o_victim_idx are 0 for non-fill responses, and hold their value when no response is issued.
- Back-to-back requests to the same set always see the prior update; no forwarding is needed because storage is flops.
- Reset asserted mid-operation: a pending response is dropped (o_rsp_valid=0 next cycle) and INIT restarts from set 0.
- The permutation invariant holds after every operation; an assertion checks it.

Test Plan:
- Reset, WAY_NUM=4, LINE_NUM=64 -> o_ready low for exactly 16 cycles after reset release, then high; requests during init produce no o_rsp_valid.
- Fill index 3, i_valid_way=0000 -> o_victim_way=0001, idx 0; then fill index 3, i_valid_way=0001 -> victim 0010, idx 1.
- Fresh set 5, fill with i_valid_way=1111 -> victim 1000, idx 3. Then touch 0001, 0010, 0100 and fill full -> victim 1000 again, because way 3 is the fill MRU followed by three touches... Corrected sequence: touch 1000, 0001, 0010, 0100 -> fill full -> victim 1000.
- Set 7: touch 0001, 0010, 0100, 1000, then invalidate 0100 -> fill full -> victim 0100, idx 2.
- Back-to-back touches to set 2 on consecutive cycles (0001 then 0010), then fill full -> victim 1000; response pulses on every cycle.
- Flush while in RUN -> response pulse, o_ready low 16 cycles, set 5 ages back to identity. Reset asserted in the cycle after a fill accept -> no o_rsp_valid, INIT restarts.
